// File: rtl/config_seq.sv
// -----------------------------------------------------------------------------
// config_seq
//   Two-requester write sequencer for a 16x4 configuration register file.
//   A granted burst of 1..8 nibbles is emitted one nibble per cycle on
//   cfg_data_out as {address, nibble}, with the address incrementing mod 16.
//   Arbitration between simultaneous requesters alternates, starting with req0.
//
// Ports
//   clk_in                      clock, rising edge
//   rstn_in                     asynchronous active-low reset
//   reqN_valid_in               requester N has a pending burst
//   reqN_ready_out              burst accepted when valid & ready on an edge
//   reqN_addr_in  [3:0]         start register address
//   reqN_len_in   [2:0]         nibble count minus one
//   reqN_data_in  [31:0]        payload, nibble k = bits [4k+3:4k]
//   cfg_data_out  [7:0]         registered {address, nibble} write word
//   busy_out                    high while writing and in the done cycle
//   done_out                    one-cycle pulse on burst completion
//   grant_out                   requester index of current / last burst
//
// Configuration
//   CONFIG_SEQ_SHADOW_EN        adds a 16x4 shadow copy of every emitted
//                               nibble, read combinationally through
//                               shadow_addr_in [3:0] -> shadow_data_out [3:0]
// -----------------------------------------------------------------------------
module config_seq (
   input  logic        clk_in,
   input  logic        rstn_in,
   input  logic        req0_valid_in,
   input  logic        req1_valid_in,
   output logic        req0_ready_out,
   output logic        req1_ready_out,
   input  logic [3:0]  req0_addr_in,
   input  logic [3:0]  req1_addr_in,
   input  logic [2:0]  req0_len_in,
   input  logic [2:0]  req1_len_in,
   input  logic [31:0] req0_data_in,
   input  logic [31:0] req1_data_in,
   output logic [7:0]  cfg_data_out,
   output logic        busy_out,
   output logic        done_out,
   output logic        grant_out
`ifdef CONFIG_SEQ_SHADOW_EN
   ,
   input  logic [3:0]  shadow_addr_in,
   output logic [3:0]  shadow_data_out
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_t;

   state_t      r_state;
   logic        r_last;      // requester served by the most recent burst
   logic [3:0]  r_addr;      // address of the word currently on cfg_data_out
   logic [2:0]  r_cnt;       // nibbles still to emit after the current one
   logic [27:0] r_data;      // remaining nibbles, next one in [3:0]

   logic        w_idle;
   logic        w_grant_idx;
   logic        w_accept;
   logic [3:0]  w_sel_addr;
   logic [2:0]  w_sel_len;
   logic [31:0] w_sel_data;
   logic        w_emit;
   logic [3:0]  w_emit_addr;
   logic [3:0]  w_emit_nib;

   // Tie goes to the requester not served last; otherwise whoever is valid.
   assign w_idle      = (r_state == ST_IDLE);
   assign w_grant_idx = (req0_valid_in && req1_valid_in) ? ~r_last : req1_valid_in;
   assign w_accept    = w_idle && (req0_valid_in || req1_valid_in);

   assign req0_ready_out = w_accept && !w_grant_idx;
   assign req1_ready_out = w_accept &&  w_grant_idx;

   assign w_sel_addr = w_grant_idx ? req1_addr_in : req0_addr_in;
   assign w_sel_len  = w_grant_idx ? req1_len_in  : req0_len_in;
   assign w_sel_data = w_grant_idx ? req1_data_in : req0_data_in;

   // Word driven onto cfg_data_out at the coming edge: first nibble on
   // acceptance, following nibbles while more remain in WRITE.
   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      w_emit      = 1'b0;
      w_emit_addr = r_addr;
      w_emit_nib  = r_data[3:0];
      if (w_accept) begin
         w_emit      = 1'b1;
         w_emit_addr = w_sel_addr;
         w_emit_nib  = w_sel_data[3:0];
      end else if (r_state == ST_WRITE && r_cnt != 3'd0) begin
         w_emit      = 1'b1;
         w_emit_addr = r_addr + 4'd1;
         w_emit_nib  = r_data[3:0];
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         r_state      <= ST_IDLE;
         r_last       <= 1'b1;
         r_addr       <= 4'h0;
         r_cnt        <= 3'd0;
         r_data       <= 28'h0;
         cfg_data_out <= 8'h00;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
         grant_out    <= 1'b0;
      end else begin
         if (w_emit) begin
            cfg_data_out <= {w_emit_addr, w_emit_nib};
         end
         case (r_state)
            ST_IDLE: begin
               done_out <= 1'b0;
               if (w_accept) begin
                  r_addr    <= w_sel_addr;
                  r_cnt     <= w_sel_len;
                  r_data    <= w_sel_data[31:4];
                  grant_out <= w_grant_idx;
                  r_last    <= w_grant_idx;
                  busy_out  <= 1'b1;
                  r_state   <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (r_cnt == 3'd0) begin
                  done_out <= 1'b1;
                  r_state  <= ST_DONE;
               end else begin
                  r_cnt  <= r_cnt - 3'd1;
                  r_addr <= w_emit_addr;
                  r_data <= {4'h0, r_data[27:4]};
               end
            end
            ST_DONE: begin
               done_out <= 1'b0;
               busy_out <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef CONFIG_SEQ_SHADOW_EN
   logic [3:0] r_shadow [16];

   // NOTE: this small array is reset so it reads all-zero before any write.
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         for (int i = 0; i < 16; i++) begin
            r_shadow[i] <= 4'h0;
         end
      end else if (w_emit) begin
         r_shadow[w_emit_addr] <= w_emit_nib;
      end
   end

   assign shadow_data_out = r_shadow[shadow_addr_in];
`endif

endmodule

// File: doc/config_seq.md
CONFIG_SEQ -- requirements
Module: config_seq

Interface
REQ-001 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-002 rstn_in  input  1  asynchronous, active-low reset.
REQ-003 req0_valid_in / req1_valid_in  input  1  requester has a pending write burst.
REQ-004 req0_ready_out / req1_ready_out  output  1  burst accepted on the rising edge where valid and ready are both 1.
REQ-005 req0_addr_in / req1_addr_in  input  4  start register address.
REQ-006 req0_len_in / req1_len_in  input  3  nibble count minus 1 (0..7 gives 1..8 nibbles).
REQ-007 req0_data_in / req1_data_in  input  32  payload; nibble k = bits [4k+3:4k].
REQ-008 cfg_data_out  output  8  {address[3:0], nibble[3:0]} word to the 16x4 config register file; registered.
REQ-009 busy_out  output  1  high in WRITE and DONE.
REQ-010 done_out  output  1  one-cycle pulse on burst completion.
REQ-011 grant_out  output  1  requester index of the current or last burst.

Function
REQ-012 States: IDLE, WRITE and DONE.
REQ-013 Arbitration (combinational, IDLE only): one valid wins; both valid: grant the requester not served last; neither: no grant.
REQ-014 reqN_ready_out = (state==IDLE) and reqN granted; never both high.
REQ-015 On acceptance edge (cycle N): latch addr, len, data, grant; cfg_data_out <= {addr, data[3:0]}; state -> WRITE.
REQ-016 Nibble k SHALL appear on cfg_data_out during cycle N+1+k, k=0..len, address field = (addr+k) mod 16.
REQ-017 Address wrap: addr=0xE, len=3 writes registers E, F, 0, 1.
REQ-018 After nibble len, state -> DONE for exactly one cycle (N+2+len): done_out=1, cfg_data_out holds last word.
REQ-019 DONE -> IDLE unconditionally; earliest next acceptance at cycle N+3+len.
REQ-020 In IDLE, cfg_data_out holds the last word (a harmless rewrite of the same value).
REQ-021 Valid deasserted before acceptance: no effect, no state change.
REQ-022 Requester inputs ignored outside the acceptance edge; payload changes mid-burst do not alter the burst.
REQ-023 last-served register updates only on acceptance.

Reset
REQ-024 rstn_in low asynchronously forces: state IDLE, cfg_data_out=8'h00, busy_out=0, done_out=0, grant_out=0, last-served=1 (req0 wins first tie).
REQ-025 Reset during WRITE aborts the burst; no done_out pulse for the aborted burst; remaining nibbles are not emitted.

Configuration
REQ-026 Macro CONFIG_SEQ_SHADOW_EN defined: adds input shadow_addr_in[3:0] and output shadow_data_out[3:0]; a 16x4 shadow array records each emitted nibble at its address on the same edge it is driven on cfg_data_out, resets to all zero, and reads combinationally.
REQ-027 CONFIG_SEQ_SHADOW_EN undefined: shadow ports and array absent; all other behaviour identical.

Verification
REQ-028 req0 addr=3 len=2 data=0x00000CBA accepted at cycle 0: cfg_data_out 0x3A, 0x4B, 0x5C in cycles 1-3; done_out high in cycle 4; req0_ready_out high again in cycle 5.
REQ-029 Both valid from reset, held: req0 served first, req1 second, req0 third (alternating grant_out 0,1,0).
REQ-030 req1 addr=0xE len=3 data=0x4321: words 0xE1, 0xF2, 0x03, 0x14.
REQ-031 len=7 data=0x89ABCDEF addr=0: 8 words 0x0F..0x78, busy_out high 9 cycles.
REQ-032 rstn_in low in cycle 2 of a len=5 burst: cfg_data_out=0x00 immediately, no done_out pulse, ready high after release.
REQ-033 CONFIG_SEQ_SHADOW_EN defined, after REQ-028 burst: shadow_addr_in=4 gives 0xB, shadow_addr_in=6 gives 0x0.
